gmii2fifo18: RTL and testbench
==============================

Name: gmii2fifo18

Overview:
- GMII receive-side framer for the ethpipe capture path.
- Strips preamble/SFD, packs received bytes two per 18-bit word into a data FIFO, and appends Gap separator words after each frame.
- Per frame, writes the byte length plus a 64-bit arrival timestamp taken from global_counter into a length FIFO.
- Runs entirely in the GMII RX clock domain; FIFOs are external.

Parameters:
- Gap, 4'h4, number of all-zero separator words written to the data FIFO after each frame (0..15).

Ports:
- gmii_rx_clk  in  1  sole clock; all logic on rising edge.
- sys_rst  in  1  synchronous, active-low reset (0 = reset).
- global_counter  in  64  free-running timestamp source.
- gmii_rx_dv  in  1  GMII receive data valid.
- gmii_rxd  in  8  GMII receive byte.
- data_din  out  18  data FIFO word: [17] high-byte valid, [16] low-byte valid, [15:8] first byte, [7:0] second byte.
- data_full  in  1  data FIFO full.
- data_wr_en  out  1  data FIFO write strobe.
- len_din  out  18  length FIFO word.
- len_full  in  1  length FIFO full.
- len_wr_en  out  1  length FIFO write strobe.
- wr_clk  out  1  FIFO write clock; equals gmii_rx_clk (combinational pass-through).

Behaviour:
- All outputs except wr_clk are registered.
- Reset (sys_rst=0 at a clock edge):
  - data_wr_en=0, len_wr_en=0, data_din=0, len_din=0.
  - FSM to IDLE; byte counter and flags cleared.
- FSM states: IDLE, PREAMBLE, DATA, POST, DROP.
- IDLE:
  - dv=1 -> PREAMBLE; the first byte is tested for 0xD5 in that same cycle.
- PREAMBLE:
  - Bytes are discarded.
  - Byte 0xD5 with dv=1 is the SFD: capture ts=global_counter that cycle.
    - If data_full=1 -> DROP; else -> DATA, with length=0 and trunc=0.
  - dv=0 before SFD -> IDLE; nothing written.
- DATA (each dv=1 cycle):
  - length increments, saturating at 16'hFFFF.
  - Even-position byte is held as the high byte.
  - Odd-position byte completes a word: next cycle data_wr_en=1, data_din={2'b11,hi,lo}.
  - Sustained rate: one write every 2 cycles.
- DATA exit: dv=0 -> POST.
- POST, data FIFO side, in order:
  - If the byte count is odd: tail word {2'b10,hi,8'h00} on the first POST cycle.
  - Then Gap words of 18'h00000.
- POST, length FIFO side, in parallel, starting on the first POST cycle, 5 consecutive cycles:
  - {trunc,1'b0,length[15:0]}
  - {2'b00,ts[63:48]}
  - {2'b00,ts[47:32]}
  - {2'b00,ts[31:16]}
  - {2'b01,ts[15:0]}
- POST exit: after max(5, tail+Gap) cycles -> IDLE, or -> PREAMBLE if dv=1 on the completion edge.
- dv during POST: if dv rises while POST runs, the frame is dropped entirely (DROP); the next frame is accepted only if dv rises in IDLE.
- DROP: no writes until dv=0, then -> IDLE.
- Full handling:
  - Every write is suppressed in any cycle where its FIFO's full input is 1; the word is lost.
  - data_full=1 at any data-word write in DATA sets trunc=1.
  - Once trunc=1, all further data words and the tail are suppressed for that frame; length counting continues; Gap words are still attempted.
  - len_full suppresses individual length-FIFO words only, with no effect on the data path.
- Reset takes priority in every state; reset mid-frame aborts with no further writes.
- Frame with 0 bytes after SFD: length word 18'h00000, no tail, Gap words and timestamp still written.

Test Plan:
- Reset: hold sys_rst=0 for 2 clocks with dv toggling -> data_wr_en=0, len_wr_en=0, data_din=0, len_din=0 throughout.
- Even frame: 55×7, D5, then 11 22 33 44; Gap=4; global_counter=100 at the SFD cycle -> data words 0x31122, 0x33344, then four 0x00000; length words 0x00004, 0x00000, 0x00000, 0x00000, 0x10064.
- Odd frame: D5, then AA BB CC -> data 0x3AABB, tail 0x2CC00, four zero words; length word 0x00003.
- No SFD: dv=1 for 8 bytes of 0x55, then dv=0 -> no writes on either FIFO.
- Mid-frame data_full: 64-byte frame with data_full=1 during word 10 -> words 10+ and the tail are absent; length word 0x20040.
- Back-to-back: second frame's dv rises 2 cycles after the first ends -> second frame fully dropped; a third frame after ≥6 idle cycles is captured normally.

Source files
------------

// File: rtl/gmii2fifo18.sv
// GMII receive framer: strips preamble/SFD, packs bytes two per 18-bit data word,
// appends Gap zero words per frame and emits a length + 64-bit timestamp record.
module gmii2fifo18 #(
  parameter logic [3:0] Gap = 4'h4
) (
  input  logic        gmii_rx_clk,
  input  logic        sys_rst,
  input  logic [63:0] global_counter,
  input  logic        gmii_rx_dv,
  input  logic [7:0]  gmii_rxd,
  output logic [17:0] data_din,
  input  logic        data_full,
  output logic        data_wr_en,
  output logic [17:0] len_din,
  input  logic        len_full,
  output logic        len_wr_en,
  output logic        wr_clk
);

  typedef enum logic [2:0] {IDLE, PREAMBLE, DATA, POST, DROP} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] len_q, len_d;
  logic [63:0] ts_q, ts_d;
  logic [7:0]  hi_q, hi_d;
  logic        odd_q, odd_d;
  logic        trunc_q, trunc_d;
  logic        drop_q, drop_d;
  logic [17:0] data_din_q, data_din_d;
  logic        data_wr_en_q, data_wr_en_d;
  logic [17:0] len_din_q, len_din_d;
  logic        len_wr_en_q, len_wr_en_d;

  logic [4:0]  slots;
  logic [4:0]  post_last;
  logic        sfd;

  assign wr_clk     = gmii_rx_clk;
  assign data_din   = data_din_q;
  assign data_wr_en = data_wr_en_q;
  assign len_din    = len_din_q;
  assign len_wr_en  = len_wr_en_q;

  // POST lasts for the longer of the 5-word length record and tail+Gap data words.
  assign slots     = {4'd0, odd_q} + {1'b0, Gap};
  assign post_last = (slots > 5'd5) ? (slots - 5'd1) : 5'd4;
  assign sfd       = gmii_rx_dv && (gmii_rxd == 8'hD5);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    ts_d         = ts_q;
    hi_d         = hi_q;
    odd_d        = odd_q;
    trunc_d      = trunc_q;
    drop_d       = drop_q;
    data_din_d   = data_din_q;
    data_wr_en_d = 1'b0;
    len_din_d    = len_din_q;
    len_wr_en_d  = 1'b0;

    case (state_q)
      IDLE, PREAMBLE: begin
        if (sfd) begin
          ts_d    = global_counter;
          len_d   = 16'h0000;
          trunc_d = 1'b0;
          odd_d   = 1'b0;
          state_d = data_full ? DROP : DATA;
        end else if (gmii_rx_dv) begin
          state_d = PREAMBLE;
        end else begin
          state_d = IDLE;
        end
      end

      DATA: begin
        if (gmii_rx_dv) begin
          if (len_q != 16'hFFFF) len_d = len_q + 16'd1;
          odd_d = ~odd_q;
          if (!odd_q) begin
            hi_d = gmii_rxd;
          end else if (!trunc_q) begin
            // A word lost to a full FIFO truncates the rest of the frame.
            if (data_full) begin
              trunc_d = 1'b1;
            end else begin
              data_wr_en_d = 1'b1;
              data_din_d   = {2'b11, hi_q, gmii_rxd};
            end
          end
        end else begin
          state_d = POST;
          cnt_d   = 5'd0;
          drop_d  = 1'b0;
        end
      end

      POST: begin
        if (cnt_q < slots) begin
          if (odd_q && (cnt_q == 5'd0)) begin
            if (!trunc_q && !data_full) begin
              data_wr_en_d = 1'b1;
              data_din_d   = {2'b10, hi_q, 8'h00};
            end
          end else if (!data_full) begin
            data_wr_en_d = 1'b1;
            data_din_d   = 18'h00000;
          end
        end
        if ((cnt_q < 5'd5) && !len_full) begin
          len_wr_en_d = 1'b1;
          case (cnt_q)
            5'd0:    len_din_d = {trunc_q, 1'b0, len_q};
            5'd1:    len_din_d = {2'b00, ts_q[63:48]};
            5'd2:    len_din_d = {2'b00, ts_q[47:32]};
            5'd3:    len_din_d = {2'b00, ts_q[31:16]};
            default: len_din_d = {2'b01, ts_q[15:0]};
          endcase
        end
        cnt_d = cnt_q + 5'd1;
        // A frame starting while the record is still being written is discarded.
        if (cnt_q == post_last) begin
          if (drop_q) state_d = gmii_rx_dv ? DROP : IDLE;
          else        state_d = gmii_rx_dv ? PREAMBLE : IDLE;
        end else if (gmii_rx_dv) begin
          drop_d = 1'b1;
        end
      end

      DROP: begin
        if (!gmii_rx_dv) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge gmii_rx_clk) begin
    if (!sys_rst) begin
      state_q      <= IDLE;
      cnt_q        <= 5'd0;
      len_q        <= 16'h0000;
      ts_q         <= 64'd0;
      hi_q         <= 8'h00;
      odd_q        <= 1'b0;
      trunc_q      <= 1'b0;
      drop_q       <= 1'b0;
      data_din_q   <= 18'h00000;
      data_wr_en_q <= 1'b0;
      len_din_q    <= 18'h00000;
      len_wr_en_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      ts_q         <= ts_d;
      hi_q         <= hi_d;
      odd_q        <= odd_d;
      trunc_q      <= trunc_d;
      drop_q       <= drop_d;
      data_din_q   <= data_din_d;
      data_wr_en_q <= data_wr_en_d;
      len_din_q    <= len_din_d;
      len_wr_en_q  <= len_wr_en_d;
    end
  end

endmodule

// File: tb/tb_gmii2fifo18.sv
// Directed bench for gmii2fifo18: frame vectors from a table plus hand-written
// sequences for reset, missing SFD, mid-frame FIFO full and back-to-back frames.
module tb_gmii2fifo18;

  logic        clk = 1'b0;
  logic        sys_rst;
  logic [63:0] global_counter;
  logic        gmii_rx_dv;
  logic [7:0]  gmii_rxd;
  logic [17:0] data_din;
  logic        data_full;
  logic        data_wr_en;
  logic [17:0] len_din;
  logic        len_full;
  logic        len_wr_en;
  logic        wr_clk;

  gmii2fifo18 #(.Gap(4'h4)) dut (
    .gmii_rx_clk   (clk),
    .sys_rst       (sys_rst),
    .global_counter(global_counter),
    .gmii_rx_dv    (gmii_rx_dv),
    .gmii_rxd      (gmii_rxd),
    .data_din      (data_din),
    .data_full     (data_full),
    .data_wr_en    (data_wr_en),
    .len_din       (len_din),
    .len_full      (len_full),
    .len_wr_en     (len_wr_en),
    .wr_clk        (wr_clk)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [17:0] dq[$];
  logic [17:0] lq[$];
  logic [17:0] edq[$];
  logic [17:0] elq[$];
  logic [7:0]  pay [0:63];
  int          full_lo = -1;
  int          full_hi = -1;

  localparam logic [63:0] JUNK_TS = 64'hDEAD_BEEF_0BAD_F00D;

  typedef struct {
    int            npre;
    int            n;
    logic [31:0]   bytes;   // payload, first byte in [31:24]
    logic [63:0]   ts;
    int            nd;
    logic [143:0]  ed;      // expected data words, word 0 in [17:0]
    logic [17:0]   len0;
  } vec_t;

  always @(negedge clk) begin
    if (data_wr_en) dq.push_back(data_din);
    if (len_wr_en)  lq.push_back(len_din);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic dv, input logic [7:0] d);
    gmii_rx_dv = dv;
    gmii_rxd   = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00);
  endtask

  task automatic send_frame(input int npre, input int n, input logic [63:0] ts);
    for (int i = 0; i < npre; i++) cyc(1'b1, 8'h55);
    global_counter = ts;
    cyc(1'b1, 8'hD5);
    global_counter = JUNK_TS;
    for (int i = 0; i < n; i++) begin
      data_full = (i >= full_lo) && (i <= full_hi);
      cyc(1'b1, pay[i]);
    end
    data_full = 1'b0;
    cyc(1'b0, 8'h00);
  endtask

  task automatic push_ts(input logic [17:0] len0, input logic [63:0] ts);
    elq.push_back(len0);
    elq.push_back({2'b00, ts[63:48]});
    elq.push_back({2'b00, ts[47:32]});
    elq.push_back({2'b00, ts[31:16]});
    elq.push_back({2'b01, ts[15:0]});
  endtask

  task automatic check_queues(input string tag);
    $display("frame %s: data words=%0d len words=%0d", tag, dq.size(), lq.size());
    chk({tag, "_ndata"}, dq.size(), edq.size());
    for (int i = 0; i < edq.size() && i < dq.size(); i++)
      chk($sformatf("%s_data%0d", tag, i), {14'd0, dq[i]}, {14'd0, edq[i]});
    chk({tag, "_nlen"}, lq.size(), elq.size());
    for (int i = 0; i < elq.size() && i < lq.size(); i++)
      chk($sformatf("%s_len%0d", tag, i), {14'd0, lq[i]}, {14'd0, elq[i]});
    dq.delete(); lq.delete(); edq.delete(); elq.delete();
  endtask

  vec_t vec [5];

  initial begin
    vec[0] = '{7, 4, 32'h11223344, 64'd100, 6,
               {18'h0, 18'h0, 18'h0, 18'h0, 18'h0, 18'h0, 18'h33344, 18'h31122}, 18'h00004};
    vec[1] = '{0, 3, 32'hAABBCC00, 64'h0123_4567_89AB_CDEF, 6,
               {18'h0, 18'h0, 18'h0, 18'h0, 18'h0, 18'h0, 18'h2CC00, 18'h3AABB}, 18'h00003};
    vec[2] = '{2, 0, 32'h0, 64'hFFFF_0000_1234_8000, 4,
               {18'h0, 18'h0, 18'h0, 18'h0, 18'h0, 18'h0, 18'h0, 18'h0}, 18'h00000};
    vec[3] = '{1, 1, 32'h5A000000, 64'd7, 5,
               {18'h0, 18'h0, 18'h0, 18'h0, 18'h0, 18'h0, 18'h0, 18'h25A00}, 18'h00001};
    vec[4] = '{3, 2, 32'hD5D50000, 64'd5, 5,
               {18'h0, 18'h0, 18'h0, 18'h0, 18'h0, 18'h0, 18'h0, 18'h3D5D5}, 18'h00002};

    sys_rst = 1'b0; gmii_rx_dv = 1'b0; gmii_rxd = 8'h00;
    data_full = 1'b0; len_full = 1'b0; global_counter = JUNK_TS;

    // Reset held for two clocks with dv toggling and an SFD byte present.
    for (int i = 0; i < 2; i++) begin
      gmii_rx_dv = i[0];
      gmii_rxd   = 8'hD5;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("rst_data_wr_en%0d", i), {31'd0, data_wr_en}, 32'd0);
      chk($sformatf("rst_len_wr_en%0d", i), {31'd0, len_wr_en}, 32'd0);
      chk($sformatf("rst_data_din%0d", i), {14'd0, data_din}, 32'd0);
      chk($sformatf("rst_len_din%0d", i), {14'd0, len_din}, 32'd0);
    end
    gmii_rx_dv = 1'b0;
    @(posedge clk); #1;
    sys_rst = 1'b1;
    idle(3);
    dq.delete(); lq.delete();

    for (int v = 0; v < 5; v++) begin
      for (int k = 0; k < 4; k++) pay[k] = vec[v].bytes[31-8*k -: 8];
      send_frame(vec[v].npre, vec[v].n, vec[v].ts);
      idle(12);
      for (int k = 0; k < vec[v].nd; k++) edq.push_back(vec[v].ed[18*k +: 18]);
      push_ts(vec[v].len0, vec[v].ts);
      check_queues($sformatf("vec%0d", v));
    end

    // Preamble only, never an SFD.
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'h55);
    idle(12);
    check_queues("nosfd");

    // Reset asserted mid-frame before any word completes.
    for (int i = 0; i < 7; i++) cyc(1'b1, 8'h55);
    cyc(1'b1, 8'hD5);
    cyc(1'b1, 8'h11);
    sys_rst = 1'b0;
    cyc(1'b1, 8'h22);
    sys_rst = 1'b1;
    idle(12);
    check_queues("midreset");

    // 64-byte frame with data_full during word 10 (bytes 20 and 21).
    for (int i = 0; i < 64; i++) pay[i] = 8'(i);
    full_lo = 20; full_hi = 21;
    send_frame(7, 64, 64'h0000_0000_0000_1000);
    full_lo = -1; full_hi = -1;
    idle(12);
    for (int i = 0; i < 10; i++) edq.push_back({2'b11, 8'(2*i), 8'(2*i+1)});
    for (int i = 0; i < 4; i++) edq.push_back(18'h00000);
    push_ts(18'h20040, 64'h0000_0000_0000_1000);
    check_queues("trunc");

    // Back-to-back: B starts 2 cycles after A ends and is dropped; C follows a long gap.
    pay[0] = 8'h01; pay[1] = 8'h02;
    send_frame(7, 2, 64'd1);
    idle(1);
    pay[0] = 8'hE1; pay[1] = 8'hE2; pay[2] = 8'hE3; pay[3] = 8'hE4;
    send_frame(7, 4, 64'd2);
    idle(6);
    pay[0] = 8'h0A; pay[1] = 8'h0B;
    send_frame(7, 2, 64'd9);
    idle(12);
    edq.push_back(18'h30102);
    for (int i = 0; i < 4; i++) edq.push_back(18'h00000);
    edq.push_back(18'h30A0B);
    for (int i = 0; i < 4; i++) edq.push_back(18'h00000);
    push_ts(18'h00002, 64'd1);
    push_ts(18'h00002, 64'd9);
    check_queues("b2b");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
